alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one RV32 ALU instruction per request, drives a registered
// operation and operand pair to an external combinational ALU, holds them for
// SETTLE_CYCLES cycles, then captures the ALU result and returns it over a
// valid/ready response handshake.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  request handshake (ready only while idle)
//   opcode_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i, imm_i  instruction fields/operands
//   ALU_Operation_o, A_o, B_o  registered drive to the ALU
//   ALU_Result_i, Zero_i       combinational ALU return
//   rsp_valid_o / rsp_ready_i  response handshake
//   rsp_result_o, rsp_zero_o, rsp_illegal_o  response payload
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  output logic [3:0]  ALU_Operation_o,
  output logic [31:0] A_o,
  output logic [31:0] B_o,
  input  logic [31:0] ALU_Result_i,
  input  logic        Zero_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_illegal_o
);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpOr  = 4'b0101;
  localparam logic [3:0] OpSll = 4'b1000;
  localparam logic [3:0] OpSrl = 4'b1010;

  localparam logic [6:0] OpcReg = 7'b0110011;
  localparam logic [6:0] OpcImm = 7'b0010011;
  localparam logic [6:0] OpcLui = 7'b0110111;

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        illegal_q;

  logic        accept, capture;
  logic [3:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic        dec_legal;

  // Instruction decode. Anything not explicitly legal issues ADD 0+0 flagged illegal.
  always_comb begin
    dec_op    = OpAdd;
    dec_a     = '0;
    dec_b     = '0;
    dec_legal = 1'b0;
    unique case (opcode_i)
      OpcReg: begin
        if (funct7_i == 7'b0000000) begin
          dec_legal = 1'b1;
          case (funct3_i)
            3'b000:  dec_op = OpAdd;
            3'b110:  dec_op = OpOr;
            3'b001:  dec_op = OpSll;
            3'b101:  dec_op = OpSrl;
            default: dec_legal = 1'b0;
          endcase
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          dec_legal = 1'b1;
          dec_op    = OpSub;
        end
        if (dec_legal) begin
          dec_a = rs1_data_i;
          dec_b = rs2_data_i;
        end
      end
      OpcImm: begin
        case (funct3_i)
          3'b000: begin dec_legal = 1'b1; dec_op = OpAdd; end
          3'b110: begin dec_legal = 1'b1; dec_op = OpOr;  end
          // Shift-immediates only exist in their funct7 == 0 form here.
          3'b001: begin dec_legal = (funct7_i == 7'b0000000); dec_op = OpSll; end
          3'b101: begin dec_legal = (funct7_i == 7'b0000000); dec_op = OpSrl; end
          default: dec_legal = 1'b0;
        endcase
        if (dec_legal) begin
          dec_a = rs1_data_i;
          dec_b = imm_i;
        end else begin
          dec_op = OpAdd;
        end
      end
      OpcLui: begin
        dec_legal = 1'b1;
        dec_op    = OpAdd;
        dec_b     = imm_i;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign accept      = (state_q == StIdle) && req_valid_i;
  assign capture     = (state_q == StExec) && (cnt_q == 4'd0);
  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid_i) state_d = StExec;
      StExec:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU drive is only loaded on accept, so it holds through EXEC, RESP and IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ALU_Operation_o <= OpAdd;
      A_o             <= '0;
      B_o             <= '0;
      illegal_q       <= 1'b0;
      cnt_q           <= '0;
    end else if (accept) begin
      ALU_Operation_o <= dec_op;
      A_o             <= dec_a;
      B_o             <= dec_b;
      illegal_q       <= ~dec_legal;
      cnt_q           <= CntLoad;
    end else if (state_q == StExec && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // The payload, including the illegal flag, changes only at capture so it stays
  // valid after the handshake until the next result lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_o  <= '0;
      rsp_zero_o    <= 1'b0;
      rsp_illegal_o <= 1'b0;
    end else if (capture) begin
      rsp_result_o  <= ALU_Result_i;
      rsp_zero_o    <= Zero_i;
      rsp_illegal_o <= illegal_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared instruction fields; each DUT has its own reset and request valid.
  logic        reset, reset4, req_valid, req_valid4, rsp_ready;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2, imm;

  logic        req_ready, rsp_valid, rsp_zero, rsp_illegal, alu_zero;
  logic [3:0]  alu_op;
  logic [31:0] a, b, alu_res, rsp_result;

  logic        req_ready4, rsp_valid4, rsp_zero4, rsp_illegal4, alu_zero4;
  logic [3:0]  alu_op4;
  logic [31:0] a4, b4, alu_res4, rsp_result4;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        illegal;
  } exp_t;
  exp_t sb[$];

  // Behavioural model of the external ALU.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    case (op)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0101: return x | y;
      4'b1000: return x << y[4:0];
      4'b1010: return x >> y[4:0];
      default: return 32'hdead_beef;
    endcase
  endfunction

  always_comb begin
    alu_res   = alu_f(alu_op, a, b);
    alu_zero  = (alu_res == 32'd0);
    alu_res4  = alu_f(alu_op4, a4, b4);
    alu_zero4 = (alu_res4 == 32'd0);
  end

  alu_issue_ctrl #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm),
    .ALU_Operation_o(alu_op), .A_o(a), .B_o(b),
    .ALU_Result_i(alu_res), .Zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_illegal_o(rsp_illegal)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset4), .req_valid_i(req_valid4), .req_ready_o(req_ready4),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm),
    .ALU_Operation_o(alu_op4), .A_o(a4), .B_o(b4),
    .ALU_Result_i(alu_res4), .Zero_i(alu_zero4),
    .rsp_valid_o(rsp_valid4), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result4), .rsp_zero_o(rsp_zero4), .rsp_illegal_o(rsp_illegal4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
    opcode = opc; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; imm = im;
  endtask

  // Presents a request to the SETTLE_CYCLES=1 DUT, pushes the expected response and
  // checks the ALU drive right after the accept edge.
  task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [3:0] e_op, input logic [31:0] e_a,
                       input logic [31:0] e_b, input logic [31:0] e_res, input logic e_zero,
                       input logic e_ill);
    @(negedge clk);
    set_fields(opc, f3, f7, r1, r2, im);
    req_valid = 1'b1;
    check_eq({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    sb.push_back('{result: e_res, zero: e_zero, illegal: e_ill});
    @(negedge clk);
    req_valid = 1'b0;
    check_eq({tag, ".op"}, 32'(alu_op), 32'(e_op));
    check_eq({tag, ".A"}, a, e_a);
    check_eq({tag, ".B"}, b, e_b);
  endtask

  // Waits (bounded) for the response, checks latency and pops the scoreboard.
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, ".latency"}, 32'(lat), 32'd1);
    if (sb.size() == 0) begin
      check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({tag, ".result"}, rsp_result, e.result);
      check_eq({tag, ".zero"}, 32'(rsp_zero), 32'(e.zero));
      check_eq({tag, ".illegal"}, 32'(rsp_illegal), 32'(e.illegal));
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, ".valid_clr"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    logic seen;
    reset = 1'b1; reset4 = 1'b1; req_valid = 1'b0; req_valid4 = 1'b0; rsp_ready = 1'b0;
    set_fields(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst.valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.result", rsp_result, 32'd0);
    check_eq("rst.A", a, 32'd0);
    reset = 1'b0; reset4 = 1'b0;
    @(negedge clk);
    check_eq("rst.ready", 32'(req_ready), 32'd1);

    issue("add", 7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 4'b0000, 32'd5, 32'd7,
          32'd12, 1'b0, 1'b0);
    collect("add"); handshake("add");
    check_eq("add.hold_A", a, 32'd5);
    check_eq("add.hold_res", rsp_result, 32'd12);

    issue("sub", 7'b0110011, 3'b000, 7'b0100000, 32'h1234, 32'h1234, 32'd0, 4'b0001,
          32'h1234, 32'h1234, 32'd0, 1'b1, 1'b0);
    collect("sub"); handshake("sub");

    issue("slli", 7'b0010011, 3'b001, 7'h00, 32'd1, 32'd0, 32'd31, 4'b1000, 32'd1, 32'd31,
          32'h8000_0000, 1'b0, 1'b0);
    collect("slli"); handshake("slli");

    issue("lui", 7'b0110111, 3'b000, 7'h00, 32'hffff_ffff, 32'd3, 32'h1234_5000, 4'b0000,
          32'd0, 32'h1234_5000, 32'h1234_5000, 1'b0, 1'b0);
    collect("lui"); handshake("lui");

    issue("or", 7'b0110011, 3'b110, 7'h00, 32'h0000_f0f0, 32'h0000_0f0f, 32'd0, 4'b0101,
          32'h0000_f0f0, 32'h0000_0f0f, 32'h0000_ffff, 1'b0, 1'b0);
    collect("or"); handshake("or");

    // Shift amount travels unmasked on B; the ALU only uses B[4:0].
    issue("srl", 7'b0110011, 3'b101, 7'h00, 32'h8000_0000, 32'h24, 32'd0, 4'b1010,
          32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1'b0);
    collect("srl"); handshake("srl");

    issue("ill_load", 7'b0000011, 3'b010, 7'h00, 32'd9, 32'd9, 32'd9, 4'b0000, 32'd0, 32'd0,
          32'd0, 1'b1, 1'b1);
    collect("ill_load"); handshake("ill_load");

    issue("ill_srli", 7'b0010011, 3'b101, 7'b0100000, 32'd8, 32'd0, 32'd1, 4'b0000, 32'd0,
          32'd0, 32'd0, 1'b1, 1'b1);
    collect("ill_srli"); handshake("ill_srli");

    // Backpressure: response held while a new request waits.
    issue("bp", 7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0, 4'b0000, 32'd5, 32'd7,
          32'd12, 1'b0, 1'b0);
    collect("bp");
    set_fields(7'b0110011, 3'b000, 7'h00, 32'd99, 32'd99, 32'd0);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp.valid", 32'(rsp_valid), 32'd1);
      check_eq("bp.result", rsp_result, 32'd12);
      check_eq("bp.ready", 32'(req_ready), 32'd0);
      check_eq("bp.A", a, 32'd5);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("bp.release_ready", 32'(req_ready), 32'd1);
    check_eq("bp.no_early_accept", a, 32'd5);
    sb.push_back('{result: 32'd198, zero: 1'b0, illegal: 1'b0});
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("bp2.A", a, 32'd99);
    collect("bp2"); handshake("bp2");

    // SETTLE_CYCLES=4: latency then reset mid-EXEC.
    @(negedge clk);
    set_fields(7'b0110011, 3'b000, 7'h00, 32'd5, 32'd7, 32'd0);
    req_valid4 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    lat = 0;
    while (!rsp_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_eq("s4.latency", 32'(lat), 32'd4);
    check_eq("s4.result", rsp_result4, 32'd12);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("s4.valid_clr", 32'(rsp_valid4), 32'd0);

    set_fields(7'b0110011, 3'b110, 7'h00, 32'h30, 32'h03, 32'd0);
    req_valid4 = 1'b1;
    @(negedge clk);
    req_valid4 = 1'b0;
    @(negedge clk);
    reset4 = 1'b1;
    #1;
    check_eq("s4rst.op", 32'(alu_op4), 32'd0);
    check_eq("s4rst.A", a4, 32'd0);
    check_eq("s4rst.B", b4, 32'd0);
    check_eq("s4rst.result", rsp_result4, 32'd0);
    check_eq("s4rst.valid", 32'(rsp_valid4), 32'd0);
    @(negedge clk);
    reset4 = 1'b0;
    @(negedge clk);
    check_eq("s4rst.ready", 32'(req_ready4), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid4) seen = 1'b1;
    end
    check_eq("s4rst.no_rsp", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
